// File: rtl/pipe_mips32_fwd.sv
// pipe_mips32_fwd: 5-stage reduced-MIPS32 core with EX forwarding, load-use interlock and branch flush.
// Instruction and data memories are external with combinational read.
module pipe_mips32_fwd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int PC_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              halted
);
  localparam logic [5:0] OP_ADD = 6'o00, OP_SUB = 6'o01, OP_AND = 6'o02, OP_OR = 6'o03,
                         OP_SLT = 6'o04, OP_MUL = 6'o05, OP_LW = 6'o10, OP_SW = 6'o11,
                         OP_ADDI = 6'o12, OP_SUBI = 6'o13, OP_SLTI = 6'o14,
                         OP_BNEQZ = 6'o15, OP_BEQZ = 6'o16;
  localparam logic [2:0] T_RR = 3'd0, T_RM = 3'd1, T_LD = 3'd2, T_ST = 3'd3,
                         T_BR = 3'd4, T_HLT = 3'd5, T_NOP = 3'd6;
  function automatic logic [2:0] dec(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return T_RR;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return T_RM;
      OP_LW:                                         return T_LD;
      OP_SW:                                         return T_ST;
      OP_BEQZ, OP_BNEQZ:                             return T_BR;
      default:                                       return T_HLT;
    endcase
  endfunction
  logic [DATA_W-1:0] regs [32];
  logic [ADDR_W-1:0] pc, pc_inc, ifid_npc, idex_npc, target;
  logic [31:0]       ifid_ir;
  logic              ifid_valid, halt_seen;
  logic [5:0]        id_op, idex_op;
  logic [4:0]        id_rs, id_rt, id_dest, idex_rs, idex_rt, idex_dest, exmem_dest, memwb_dest;
  logic [2:0]        id_type, idex_type, exmem_type, memwb_type;
  logic              id_we, idex_we, exmem_we, memwb_we, wb_we;
  logic [DATA_W-1:0] id_imm, id_a, id_b, idex_a, idex_b, idex_imm;
  logic [DATA_W-1:0] a_f, b_f, prod, alu, exmem_alu, exmem_b, memwb_res;
  logic              stall, taken, freeze;
  assign id_op   = ifid_ir[31:26];
  assign id_rs   = ifid_ir[25:21];
  assign id_rt   = ifid_ir[20:16];
  assign id_imm  = {{(DATA_W-16){ifid_ir[15]}}, ifid_ir[15:0]};
  assign id_type = ifid_valid ? dec(id_op) : T_NOP;
  assign id_dest = id_type == T_RR ? ifid_ir[15:11] : id_rt;
  assign id_we   = (id_type == T_RR || id_type == T_RM || id_type == T_LD) && id_dest != 5'd0;
  assign wb_we   = memwb_we && !halted;
  // Write-through: a register retiring this cycle is visible to the ID read.
  assign id_a = id_rs == 5'd0 ? '0 : (wb_we && memwb_dest == id_rs) ? memwb_res : regs[id_rs];
  assign id_b = id_rt == 5'd0 ? '0 : (wb_we && memwb_dest == id_rt) ? memwb_res : regs[id_rt];
  assign stall = idex_type == T_LD && idex_rt != 5'd0 &&
                 ((id_type != T_HLT && id_type != T_NOP && id_rs == idex_rt) ||
                  ((id_type == T_RR || id_type == T_ST) && id_rt == idex_rt));
  assign freeze = halt_seen || id_type == T_HLT;
  // A load still in EX/MEM never needs forwarding here: the interlock keeps its consumer one stage back.
  assign a_f = (exmem_we && exmem_type != T_LD && exmem_dest == idex_rs) ? exmem_alu :
               (memwb_we && memwb_dest == idex_rs) ? memwb_res : idex_a;
  assign b_f = (exmem_we && exmem_type != T_LD && exmem_dest == idex_rt) ? exmem_alu :
               (memwb_we && memwb_dest == idex_rt) ? memwb_res : idex_b;
  assign prod = a_f * b_f;
  assign alu = idex_type == T_RR ?
                 (idex_op == OP_ADD ? a_f + b_f : idex_op == OP_SUB ? a_f - b_f :
                  idex_op == OP_AND ? a_f & b_f : idex_op == OP_OR ? a_f | b_f :
                  idex_op == OP_SLT ? {{(DATA_W-1){1'b0}}, a_f < b_f} : prod) :
               idex_op == OP_SUBI ? a_f - idex_imm :
               idex_op == OP_SLTI ? {{(DATA_W-1){1'b0}}, a_f < idex_imm} : a_f + idex_imm;
  assign target = idex_npc + idex_imm[ADDR_W-1:0];
  assign taken  = idex_type == T_BR && (idex_op == OP_BEQZ ? a_f == '0 : a_f != '0);
  assign pc_inc = pc + ADDR_W'(1);
  assign imem_addr  = pc;
  assign dmem_addr  = exmem_alu[ADDR_W-1:0];
  assign dmem_wdata = exmem_b;
  assign dmem_we    = exmem_type == T_ST && !halted;
  assign dbg_rdata  = dbg_raddr == 5'd0 ? '0 : regs[dbg_raddr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc         <= ADDR_W'(PC_RESET);
      ifid_valid <= 1'b0;
      ifid_ir    <= '0;
      ifid_npc   <= '0;
      halt_seen  <= 1'b0;
      idex_type  <= T_NOP;
      idex_we    <= 1'b0;
      idex_op    <= '0;
      idex_rs    <= '0;
      idex_rt    <= '0;
      idex_dest  <= '0;
      idex_a     <= '0;
      idex_b     <= '0;
      idex_imm   <= '0;
      idex_npc   <= '0;
      exmem_type <= T_NOP;
      exmem_we   <= 1'b0;
      exmem_dest <= '0;
      exmem_alu  <= '0;
      exmem_b    <= '0;
      memwb_type <= T_NOP;
      memwb_we   <= 1'b0;
      memwb_dest <= '0;
      memwb_res  <= '0;
      halted     <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc        <= taken ? target : (stall || freeze) ? pc : pc_inc;
      halt_seen <= halt_seen || (id_type == T_HLT && !taken);
      if (taken || freeze) ifid_valid <= 1'b0;
      else if (!stall) begin
        ifid_valid <= 1'b1;
        ifid_ir    <= imem_rdata;
        ifid_npc   <= pc_inc;
      end
      idex_type <= (taken || stall) ? T_NOP : id_type;
      idex_we   <= !(taken || stall) && id_we;
      idex_op   <= id_op;
      idex_rs   <= id_rs;
      idex_rt   <= id_rt;
      idex_dest <= id_dest;
      idex_a    <= id_a;
      idex_b    <= id_b;
      idex_imm  <= id_imm;
      idex_npc  <= ifid_npc;
      exmem_type <= idex_type;
      exmem_we   <= idex_we;
      exmem_dest <= idex_dest;
      exmem_alu  <= alu;
      exmem_b    <= b_f;
      memwb_type <= exmem_type;
      memwb_we   <= exmem_we;
      memwb_dest <= exmem_dest;
      memwb_res  <= exmem_type == T_LD ? dmem_rdata : exmem_alu;
      halted     <= halted || memwb_type == T_HLT;
      if (wb_we) regs[memwb_dest] <= memwb_res;
    end
endmodule
